// File: rtl/ghost_row_fetcher.sv
// Shares one synchronous sprite ROM among four ghosts: fetches next-line sprite rows into a
// shadow buffer during blanking, swaps to an active buffer on line start, and drives pixel colour.
module ghost_row_fetcher (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_start_i,
    input  logic [8:0]  fetch_line_i,
    input  logic        line_start_i,
    input  logic [8:0]  x_red_i,
    input  logic [8:0]  x_pink_i,
    input  logic [8:0]  x_blue_i,
    input  logic [8:0]  x_yellow_i,
    input  logic [8:0]  y_red_i,
    input  logic [8:0]  y_pink_i,
    input  logic [8:0]  y_blue_i,
    input  logic [8:0]  y_yellow_i,
    output logic        rom_en_o,
    output logic [7:0]  rom_addr_o,
    input  logic [11:0] rom_data_i,
    input  logic [7:0]  sx_i,
    output logic [3:0]  r_o,
    output logic [3:0]  g_o,
    output logic [3:0]  b_o,
    output logic        hit_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o
);

    localparam int unsigned NGHOST   = 4;
    localparam int unsigned SPRITE_W = 8;
    localparam int unsigned COLOR_W  = 12;
    localparam int unsigned POS_W    = 9;
    localparam int unsigned SUM_W    = POS_W + 1;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned ID_W     = 2;
    localparam int unsigned ADDR_W   = ID_W + ROW_W + COL_W;

    localparam logic [COLOR_W-1:0] TRANSPARENT = '0;
    localparam logic [ID_W-1:0]    LAST_G      = ID_W'(NGHOST - 1);
    localparam logic [COL_W-1:0]   LAST_COL    = COL_W'(SPRITE_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   g_q, g_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_vld_q;
    logic [ID_W-1:0]   rd_g_q;
    logic [COL_W-1:0]  rd_col_q;
    logic              overrun_q;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    logic              hit_q, hit_d;

    logic [POS_W-1:0]                     line_q;
    logic [NGHOST-1:0][POS_W-1:0]         x_snap_q, y_snap_q;
    logic [NGHOST-1:0]                    sh_vis_q, act_vis_q;
    logic [NGHOST-1:0][POS_W-1:0]         sh_x_q, act_x_q;
    logic [NGHOST-1:0][SPRITE_W-1:0][COLOR_W-1:0] sh_pix_q, act_pix_q;

    logic [POS_W-1:0]             y_cur_c;
    logic                         vis_c;
    logic [NGHOST-1:0]            in_c;
    logic [NGHOST-1:0][COL_W-1:0] col_c;

    // Current ghost covers the fetched line; 10-bit sum so y near 511 never wraps.
    assign y_cur_c = y_snap_q[g_q];
    assign vis_c   = ({1'b0, line_q} >= {1'b0, y_cur_c}) &&
                     ({1'b0, line_q} < ({1'b0, y_cur_c} + SUM_W'(SPRITE_W)));

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start_i) begin
                    state_d = S_CHECK;
                    g_d     = '0;
                end
            end
            S_CHECK: begin
                if (vis_c) begin
                    state_d = S_READ;
                    row_d   = line_q[ROW_W-1:0] - y_cur_c[ROW_W-1:0];
                    col_d   = '0;
                end else if (g_q == LAST_G) begin
                    state_d = S_DONE;
                end else begin
                    g_d = g_q + ID_W'(1);
                end
            end
            S_READ: begin
                if (col_q == LAST_COL) state_d = S_WAIT;
                else                   col_d   = col_q + COL_W'(1);
            end
            S_WAIT: begin
                if (g_q == LAST_G) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHECK;
                    g_d     = g_q + ID_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rom_en_d   = (state_d == S_READ);
        rom_addr_d = rom_en_d ? {g_d, row_d, col_d} : rom_addr_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // Pixel hit test per ghost; low column bits of the difference select the sprite pixel.
    for (genvar gi = 0; gi < NGHOST; gi++) begin : g_px
        assign in_c[gi]  = act_vis_q[gi] &&
                           ({2'b0, sx_i} >= {1'b0, act_x_q[gi]}) &&
                           ({2'b0, sx_i} < ({1'b0, act_x_q[gi]} + SUM_W'(SPRITE_W)));
        assign col_c[gi] = sx_i[COL_W-1:0] - act_x_q[gi][COL_W-1:0];
    end

    always_comb begin
        rgb_d = '0;
        hit_d = 1'b0;
        for (int i = 0; i < NGHOST; i++) begin
            if (!hit_d && in_c[i] && (act_pix_q[i][col_c[i]] != TRANSPARENT)) begin
                rgb_d = act_pix_q[i][col_c[i]];
                hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            sh_vis_q   <= '0;
            act_vis_q  <= '0;
            overrun_q  <= 1'b0;
            rgb_q      <= '0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_vld_q   <= rom_en_q;
            rgb_q      <= rgb_d;
            hit_q      <= hit_d;
            if (state_q == S_CHECK) sh_vis_q[g_q] <= vis_c;
            // A swap during a fetch would expose a half-built row, so the line goes blank instead.
            if (line_start_i) begin
                if (busy_q) begin
                    act_vis_q <= '0;
                    overrun_q <= 1'b1;
                end else begin
                    act_vis_q <= sh_vis_q;
                end
            end
        end
    end

    // Payload storage carries no reset; it is only observed through the visible bits.
    always_ff @(posedge clk_i) begin
        if (fetch_start_i && (state_q == S_IDLE)) begin
            line_q   <= fetch_line_i;
            x_snap_q <= {x_yellow_i, x_blue_i, x_pink_i, x_red_i};
            y_snap_q <= {y_yellow_i, y_blue_i, y_pink_i, y_red_i};
        end
        if ((state_q == S_CHECK) && vis_c) sh_x_q[g_q] <= x_snap_q[g_q];
        rd_g_q   <= rom_addr_q[ADDR_W-1 -: ID_W];
        rd_col_q <= rom_addr_q[COL_W-1:0];
        if (rd_vld_q) sh_pix_q[rd_g_q][rd_col_q] <= rom_data_i;
        if (line_start_i && !busy_q) begin
            act_x_q   <= sh_x_q;
            act_pix_q <= sh_pix_q;
        end
    end

    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;
    assign r_o        = rgb_q[11:8];
    assign g_o        = rgb_q[7:4];
    assign b_o        = rgb_q[3:0];
    assign hit_o      = hit_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

endmodule
